// File: rtl/safety_obi_reg_bridge.sv
`default_nettype none
// ============================================================================
// Module   : safety_obi_reg_bridge
// Brief    : OBI data port to single-outstanding register-interface master
//            with address-window check and local error responses.
//            Optional reg_ready_i timeout: define SAFETY_OBI_REG_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module safety_obi_reg_bridge #(
    parameter logic [31:0] PERIPH_BASE_ADDR  = 32'h0020_0000,
    parameter logic [31:0] PERIPH_ADDR_RANGE = 32'h0001_0000,
    parameter int unsigned TIMEOUT_CYCLES    = 255
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        obi_req_i,
    output logic        obi_gnt_o,
    input  logic [31:0] obi_addr_i,
    input  logic        obi_we_i,
    input  logic [3:0]  obi_be_i,
    input  logic [31:0] obi_wdata_i,
    output logic        obi_rvalid_o,
    output logic [31:0] obi_rdata_o,
    output logic        obi_err_o,
    output logic        reg_valid_o,
    output logic [31:0] reg_addr_o,
    output logic        reg_write_o,
    output logic [3:0]  reg_wstrb_o,
    output logic [31:0] reg_wdata_o,
    input  logic        reg_ready_i,
    input  logic [31:0] reg_rdata_i,
    input  logic        reg_error_i
);

    localparam logic [1:0] c_IDLE   = 2'd0;
    localparam logic [1:0] c_ACCESS = 2'd1;
`ifdef SAFETY_OBI_REG_TIMEOUT_EN
    localparam logic [1:0]  c_TIMEOUT_WAIT  = 2'd2;
    localparam logic [15:0] c_TIMEOUT_LAST  = 16'(TIMEOUT_CYCLES - 1);
    localparam logic [31:0] c_TIMEOUT_RDATA = 32'hBADC_AB1E;
`endif

    // Window must not wrap past 2^32 and the timeout must fit the 16-bit counter.
    if ((TIMEOUT_CYCLES < 1) || (TIMEOUT_CYCLES > 65535) ||
        (({1'b0, PERIPH_BASE_ADDR} + {1'b0, PERIPH_ADDR_RANGE}) > 33'h1_0000_0000)) begin : g_bad_cfg
        $error("safety_obi_reg_bridge: invalid parameter configuration");
    end

    logic [1:0]  state_q,     state_d;
    logic        reg_valid_q, reg_valid_d;
    logic [31:0] reg_addr_q,  reg_addr_d;
    logic        reg_write_q, reg_write_d;
    logic [3:0]  reg_wstrb_q, reg_wstrb_d;
    logic [31:0] reg_wdata_q, reg_wdata_d;
    logic        rvalid_q,    rvalid_d;
    logic [31:0] rdata_q,     rdata_d;
    logic        err_q,       err_d;

    logic [31:0] w_addr_offset;
    logic        w_in_window;
    logic        w_grant;
    logic        w_accept;
    logic        w_reject;

    // Unsigned offset compare handles the window without a separate lower-bound test.
    assign w_addr_offset = obi_addr_i - PERIPH_BASE_ADDR;
    assign w_in_window   = (w_addr_offset < PERIPH_ADDR_RANGE);
    assign w_grant       = obi_req_i && (state_q == c_IDLE);
    assign w_accept      = w_grant && w_in_window;
    assign w_reject      = w_grant && !w_in_window;

`ifdef SAFETY_OBI_REG_TIMEOUT_EN
    logic [15:0] cnt_q, cnt_d;
    logic        w_timeout;

    // A ready in the limit cycle takes priority over the timeout.
    assign w_timeout = (state_q == c_ACCESS) && !reg_ready_i && (cnt_q == c_TIMEOUT_LAST);
`endif

    always_ff @(posedge clk_i or posedge rst_i) begin : p_state_reg
        if (rst_i) begin
            state_q <= c_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin : p_next_state
        state_d = state_q;
        case (state_q)
            c_IDLE: begin
                if (w_accept) begin
                    state_d = c_ACCESS;
                end
            end
            c_ACCESS: begin
                if (reg_ready_i) begin
                    state_d = c_IDLE;
                end
`ifdef SAFETY_OBI_REG_TIMEOUT_EN
                else if (w_timeout) begin
                    state_d = c_TIMEOUT_WAIT;
                end
`endif
            end
`ifdef SAFETY_OBI_REG_TIMEOUT_EN
            c_TIMEOUT_WAIT: state_d = c_IDLE;
`endif
            default: state_d = c_IDLE;
        endcase
    end

    always_comb begin : p_outputs
        reg_valid_d = 1'b0;
        reg_addr_d  = reg_addr_q;
        reg_write_d = reg_write_q;
        reg_wstrb_d = reg_wstrb_q;
        reg_wdata_d = reg_wdata_q;
        rvalid_d    = 1'b0;
        rdata_d     = 32'h0;
        err_d       = 1'b0;
`ifdef SAFETY_OBI_REG_TIMEOUT_EN
        cnt_d       = cnt_q;
`endif
        if (w_accept) begin
            reg_valid_d = 1'b1;
            reg_addr_d  = obi_addr_i;
            reg_write_d = obi_we_i;
            reg_wstrb_d = obi_be_i;
            reg_wdata_d = obi_wdata_i;
`ifdef SAFETY_OBI_REG_TIMEOUT_EN
            cnt_d       = 16'h0;
`endif
        end
        if (w_reject) begin
            rvalid_d = 1'b1;
            err_d    = 1'b1;
        end
        if (state_q == c_ACCESS) begin
            if (reg_ready_i) begin
                rvalid_d = 1'b1;
                rdata_d  = reg_write_q ? 32'h0 : reg_rdata_i;
                err_d    = reg_error_i;
            end
`ifdef SAFETY_OBI_REG_TIMEOUT_EN
            else if (w_timeout) begin
                rvalid_d = 1'b1;
                rdata_d  = c_TIMEOUT_RDATA;
                err_d    = 1'b1;
            end else begin
                reg_valid_d = 1'b1;
                cnt_d       = cnt_q + 16'd1;
            end
`else
            else begin
                reg_valid_d = 1'b1;
            end
`endif
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin : p_data_reg
        if (rst_i) begin
            reg_valid_q <= 1'b0;
            reg_addr_q  <= 32'h0;
            reg_write_q <= 1'b0;
            reg_wstrb_q <= 4'h0;
            reg_wdata_q <= 32'h0;
            rvalid_q    <= 1'b0;
            rdata_q     <= 32'h0;
            err_q       <= 1'b0;
`ifdef SAFETY_OBI_REG_TIMEOUT_EN
            cnt_q       <= 16'h0;
`endif
        end else begin
            reg_valid_q <= reg_valid_d;
            reg_addr_q  <= reg_addr_d;
            reg_write_q <= reg_write_d;
            reg_wstrb_q <= reg_wstrb_d;
            reg_wdata_q <= reg_wdata_d;
            rvalid_q    <= rvalid_d;
            rdata_q     <= rdata_d;
            err_q       <= err_d;
`ifdef SAFETY_OBI_REG_TIMEOUT_EN
            cnt_q       <= cnt_d;
`endif
        end
    end

    assign obi_gnt_o    = w_grant;
    assign obi_rvalid_o = rvalid_q;
    assign obi_rdata_o  = rdata_q;
    assign obi_err_o    = err_q;
    assign reg_valid_o  = reg_valid_q;
    assign reg_addr_o   = reg_addr_q;
    assign reg_write_o  = reg_write_q;
    assign reg_wstrb_o  = reg_wstrb_q;
    assign reg_wdata_o  = reg_wdata_q;

endmodule
`default_nettype wire
